// File: rtl/axi_read_pkg.sv
// Shared AXI read-side definitions: splitter FSM encoding, 4 KB page size, burst type, beat-size helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_read_pkg;

    // AXI forbids a burst from crossing a 4 KB page
    localparam int unsigned AXI_4K_BYTES = 4096;

    // ARBURST encoding for incrementing bursts
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    // Splitter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } split_state_e;

    // log2 of the bytes-per-beat value; also gives the ARSIZE encoding
    function automatic int unsigned beat_shift(input int unsigned bpb);
        int unsigned s;
        s = 0;
        while ((32'd1 << s) < bpb) begin
            s = s + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_read_burst_splitter.sv
// Splits one linear read request into AXI INCR bursts (<= MAX_BURST_BEATS, never crossing 4 KB).
// Latency: first command two cycles after accept; one command per two cycles thereafter.
// Backpressure: command fields held stable while cmd_ready is low; no new request accepted while busy.
module axi_read_burst_splitter
    import axi_read_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH  = 32,
    parameter int C_AXI_DATA_WIDTH  = 128,
    parameter int MAX_BURST_BEATS   = 256,
    parameter int C_REQ_BEATS_WIDTH = 24
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [C_REQ_BEATS_WIDTH-1:0] req_beats,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [C_AXI_ADDR_WIDTH-1:0]  cmd_addr,
    output logic [7:0]                   cmd_len,
    output logic                         cmd_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned BPB      = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG2_BPB = beat_shift(BPB);

    // Clears the sub-beat address bits so every burst starts beat-aligned
    localparam logic [C_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(C_AXI_ADDR_WIDTH'(BPB - 1));
    localparam logic [12:0]                 PAGE_BYTES = 13'(AXI_4K_BYTES);
    localparam logic [12:0]                 MAX_LIM    = 13'(MAX_BURST_BEATS);

    split_state_e                 state_q,     state_d;
    logic [C_AXI_ADDR_WIDTH-1:0]  cur_addr_q,  cur_addr_d;
    logic [C_REQ_BEATS_WIDTH-1:0] rem_q,       rem_d;
    logic [8:0]                   burst_q,     burst_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic [C_AXI_ADDR_WIDTH-1:0]  cmd_addr_q,  cmd_addr_d;
    logic [7:0]                   cmd_len_q,   cmd_len_d;
    logic                         cmd_last_q,  cmd_last_d;
    logic                         done_q,      done_d;

    logic [12:0] to_bnd;
    logic [12:0] lim;
    logic [8:0]  burst_calc;

    // Burst size: smallest of remaining beats, the burst cap and beats left in the current 4 KB page
    always_comb begin
        to_bnd     = (PAGE_BYTES - {1'b0, cur_addr_q[11:0]}) >> LOG2_BPB;
        lim        = (to_bnd < MAX_LIM) ? to_bnd : MAX_LIM;
        burst_calc = (32'(rem_q) < 32'(lim)) ? 9'(rem_q) : 9'(lim);
    end

    // Next-state and command register updates
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        burst_d     = burst_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_last_d  = cmd_last_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cur_addr_d = req_addr & ALIGN_MASK;
                    rem_d      = req_beats;
                    if (req_beats == '0) begin
                        // Zero-length request completes immediately without a command
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                burst_d     = burst_calc;
                cmd_addr_d  = cur_addr_q;
                cmd_len_d   = 8'(burst_calc - 9'd1);
                cmd_last_d  = (32'(burst_calc) == 32'(rem_q));
                cmd_valid_d = 1'b1;
                state_d     = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    // Address advance wraps modulo the address width
                    cur_addr_d  = cur_addr_q + (C_AXI_ADDR_WIDTH'(burst_q) << LOG2_BPB);
                    rem_d       = rem_q - C_REQ_BEATS_WIDTH'(burst_q);
                    if (cmd_last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight request
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            burst_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            burst_q     <= burst_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_last_q  <= cmd_last_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_last  = cmd_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_axi_read_burst_splitter.sv
// Directed bench for axi_read_burst_splitter (BPB=16, 256-beat cap).
// Latency: checks first command at accept+2 and two-cycle spacing between bursts.
// Backpressure: stalls cmd_ready mid-request and checks the command holds stable.
module tb_axi_read_burst_splitter;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [23:0] req_beats;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    axi_read_burst_splitter #(
        .C_AXI_ADDR_WIDTH (32),
        .C_AXI_DATA_WIDTH (128),
        .MAX_BURST_BEATS  (256),
        .C_REQ_BEATS_WIDTH(24)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_beats(req_beats),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_last (cmd_last),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] a, input logic [7:0] l, input logic lst);
        check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
        check({tag, "_addr"},  64'(cmd_addr),  64'(a));
        check({tag, "_len"},   64'(cmd_len),   64'(l));
        check({tag, "_last"},  64'(cmd_last),  64'(lst));
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_beats = '0;
        cmd_ready = 1'b1;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_addr",  64'(cmd_addr),  64'd0);
        check("rst_cmd_len",   64'(cmd_len),   64'd0);
        check("rst_cmd_last",  64'(cmd_last),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        RST = 1'b0;
        tick();

        // ---------------- aligned single burst ----------------
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_beats = 24'd16;
        check("al_req_ready", 64'(req_ready), 64'd1);
        tick();                                   // accept+1: CALC
        req_valid = 1'b0;
        check("al_calc_valid", 64'(cmd_valid), 64'd0);
        check("al_calc_busy",  64'(busy),      64'd1);
        check("al_calc_rdy",   64'(req_ready), 64'd0);
        tick();                                   // accept+2: command out
        check_cmd("al_cmd", 32'h0000_1000, 8'd15, 1'b1);
        tick();                                   // handshake taken
        check("al_done",       64'(done),      64'd1);
        check("al_done_valid", 64'(cmd_valid), 64'd0);
        check("al_done_rdy",   64'(req_ready), 64'd1);
        check("al_done_busy",  64'(busy),      64'd0);
        tick();
        check("al_done_clr",   64'(done),      64'd0);

        // ------- 4 KB split + stall + request held while busy -------
        req_valid = 1'b1; req_addr = 32'h0000_1F80; req_beats = 24'd300;
        tick();                                   // accepted; next request queued on the bus
        req_addr = 32'h0000_100F; req_beats = 24'd1;
        check("sp_rdy_calc1", 64'(req_ready), 64'd0);
        tick();
        check_cmd("sp_cmd1", 32'h0000_1F80, 8'd7, 1'b0);
        check("sp_rdy_iss1", 64'(req_ready), 64'd0);
        tick();                                   // CALC for burst 2
        check("sp_gap_valid", 64'(cmd_valid), 64'd0);
        check("sp_gap_done",  64'(done),      64'd0);
        check("sp_gap_rdy",   64'(req_ready), 64'd0);
        cmd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_cmd($sformatf("sp_stall%0d", i), 32'h0000_2000, 8'd255, 1'b0);
            check($sformatf("sp_stall%0d_rdy", i), 64'(req_ready), 64'd0);
            tick();
        end
        check_cmd("sp_cmd2", 32'h0000_2000, 8'd255, 1'b0);
        cmd_ready = 1'b1;
        tick();                                   // single handshake for burst 2
        check("sp_gap2_valid", 64'(cmd_valid), 64'd0);
        tick();
        check_cmd("sp_cmd3", 32'h0000_3000, 8'd35, 1'b1);
        check("sp_cmd3_done", 64'(done), 64'd0);
        tick();
        check("sp_done",       64'(done),      64'd1);
        check("sp_done_rdy",   64'(req_ready), 64'd1);
        check("sp_done_valid", 64'(cmd_valid), 64'd0);
        tick();                                   // queued unaligned request accepted in done cycle
        req_valid = 1'b0;
        check("ua_busy",     64'(busy), 64'd1);
        check("ua_done_clr", 64'(done), 64'd0);
        tick();
        check_cmd("ua_cmd", 32'h0000_1000, 8'd0, 1'b1);
        tick();
        check("ua_done", 64'(done), 64'd1);
        tick();

        // ---------------- zero-beat request ----------------
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_beats = 24'd0;
        tick();
        req_valid = 1'b0;
        check("zb_done",  64'(done),      64'd1);
        check("zb_valid", 64'(cmd_valid), 64'd0);
        check("zb_busy",  64'(busy),      64'd0);
        check("zb_rdy",   64'(req_ready), 64'd1);
        tick();
        check("zb_done_clr", 64'(done),      64'd0);
        check("zb_valid2",   64'(cmd_valid), 64'd0);

        // ---------------- wrap at top of address space ----------------
        req_valid = 1'b1; req_addr = 32'hFFFF_FFC0; req_beats = 24'd8;
        tick();
        req_valid = 1'b0;
        waited = 0;
        while (!cmd_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("wr_wait_cycles", 64'(waited), 64'd1);
        check_cmd("wr_cmd1", 32'hFFFF_FFC0, 8'd3, 1'b0);
        tick(); tick();
        check_cmd("wr_cmd2", 32'h0000_0000, 8'd3, 1'b1);
        tick();
        check("wr_done", 64'(done), 64'd1);
        tick();

        // ---------------- reset mid-operation ----------------
        cmd_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0000; req_beats = 24'd600;
        tick();
        req_valid = 1'b0;
        tick();
        check_cmd("mr_cmd", 32'h0000_0000, 8'd255, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mr_valid", 64'(cmd_valid), 64'd0);
        check("mr_busy",  64'(busy),      64'd0);
        check("mr_rdy",   64'(req_ready), 64'd1);
        check("mr_done",  64'(done),      64'd0);
        cmd_ready = 1'b1;
        tick();
        check("mr_done2",  64'(done),      64'd0);
        check("mr_valid2", 64'(cmd_valid), 64'd0);
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_beats = 24'd20;
        tick();
        req_valid = 1'b0;
        tick();
        check_cmd("mr_new", 32'h0000_2000, 8'd19, 1'b1);
        tick();
        check("mr_new_done", 64'(done), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
